systolic_feeder: RTL

Operand sequencer driving the input edges of the M×K output-stationary systolic array. On `start` it clears the array accumulators, then streams the M×N feature matrix and the N×K weight matrix as diagonally skewed, zero-padded vectors onto the array's `X`/`W` ports, waits for the pipeline to drain, and pulses `done`. It sits between the matrix staging buffers and the array, and replaces the array's free-running cycle count as the job-completion source.

---
 rtl/systolic_feeder_if.sv | 27 ++
 rtl/systolic_feeder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder_if.sv
// Operand/control bundle between the staging buffers, the systolic feeder and the array edges.
interface systolic_feeder_if #(
   parameter int M          = 5,
   parameter int N          = 3,
   parameter int K          = 4,
   parameter int DATA_WIDTH = 32
);
   logic                         start;
   logic [DATA_WIDTH*M*N-1:0]    X_mat;
   logic [DATA_WIDTH*N*K-1:0]    W_mat;
   logic [DATA_WIDTH*M-1:0]      X;
   logic [DATA_WIDTH*K-1:0]      W;
   logic                         clr_n;
   logic                         valid;
   logic                         busy;
   logic                         done;

   modport master (
      output start, X_mat, W_mat,
      input  X, W, clr_n, valid, busy, done
   );

   modport slave (
      input  start, X_mat, W_mat,
      output X, W, clr_n, valid, busy, done
   );
endinterface

// File: rtl/systolic_feeder.sv
// Streams skewed, zero-padded operand vectors into an MxK output-stationary array.
// Define SYSTOLIC_FEEDER_LATCH_EN to capture X_mat/W_mat at the accept edge.
//
// state   | meaning
// S_IDLE  | waiting for start, all outputs quiet
// S_CLEAR | one cycle of clr_n=0 to reset the array accumulators
// S_FEED  | T=M+N+K-2 skewed vectors, t_q is the current step
// S_DRAIN | DRAIN_CYCLES cycles letting the array pipeline settle
// S_DONE  | one-cycle done pulse
module systolic_feeder #(
   parameter int M            = 5,
   parameter int N            = 3,
   parameter int K            = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   systolic_feeder_if.slave     bus
);
   localparam int T  = M + N + K - 2;
   localparam int XW = DATA_WIDTH * M;
   localparam int WW = DATA_WIDTH * K;
   localparam int XM = DATA_WIDTH * M * N;
   localparam int WM = DATA_WIDTH * N * K;

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [31:0]     t_q, t_d;
   logic [31:0]     drain_q, drain_d;
   logic [XW-1:0]   x_q, x_d;
   logic [WW-1:0]   w_q, w_d;
   logic            clr_n_q, clr_n_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [XM-1:0]   xsrc;
   logic [WM-1:0]   wsrc;
   logic [31:0]     t_next;
   logic [XW-1:0]   x_vec;
   logic [WW-1:0]   w_vec;

`ifdef SYSTOLIC_FEEDER_LATCH_EN
   logic [XM-1:0]   xm_q, xm_d;
   logic [WM-1:0]   wm_q, wm_d;

   always_comb begin
      xm_d = xm_q;
      wm_d = wm_q;
      if (state_q == S_IDLE && bus.start) begin
         xm_d = bus.X_mat;
         wm_d = bus.W_mat;
      end
   end

   assign xsrc = xm_q;
   assign wsrc = wm_q;
`else
   assign xsrc = bus.X_mat;
   assign wsrc = bus.W_mat;
`endif

   // Vector for the step about to be presented: element (i,k) lands on lane i at t=i+k.
   assign t_next = (state_q == S_FEED) ? t_q + 32'd1 : 32'd0;

   always_comb begin
      x_vec = '0;
      w_vec = '0;
      for (int i = 0; i < M; i++)
         for (int k = 0; k < N; k++)
            if (t_next == 32'(i + k))
               x_vec[DATA_WIDTH*i +: DATA_WIDTH] = xsrc[DATA_WIDTH*(i*N+k) +: DATA_WIDTH];
      for (int j = 0; j < K; j++)
         for (int k = 0; k < N; k++)
            if (t_next == 32'(j + k))
               w_vec[DATA_WIDTH*j +: DATA_WIDTH] = wsrc[DATA_WIDTH*(k*K+j) +: DATA_WIDTH];
   end

   // Next-state and next-output values; every output is a flop holding the next cycle's value.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      drain_d = drain_q;
      x_d     = '0;
      w_d     = '0;
      clr_n_d = 1'b1;
      valid_d = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               state_d = S_CLEAR;
               clr_n_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_CLEAR: begin
            state_d = S_FEED;
            t_d     = 32'd0;
            x_d     = x_vec;
            w_d     = w_vec;
            valid_d = 1'b1;
         end
         S_FEED: begin
            if (t_q == 32'(T - 1)) begin
               t_d = 32'd0;
               if (DRAIN_CYCLES == 0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_DRAIN;
                  drain_d = 32'(DRAIN_CYCLES - 1);
               end
            end else begin
               t_d     = t_next;
               x_d     = x_vec;
               w_d     = w_vec;
               valid_d = 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_q == 32'd0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q - 32'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         drain_q <= '0;
         x_q     <= '0;
         w_q     <= '0;
         clr_n_q <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SYSTOLIC_FEEDER_LATCH_EN
         xm_q    <= '0;
         wm_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         drain_q <= drain_d;
         x_q     <= x_d;
         w_q     <= w_d;
         clr_n_q <= clr_n_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SYSTOLIC_FEEDER_LATCH_EN
         xm_q    <= xm_d;
         wm_q    <= wm_d;
`endif
      end
   end

   assign bus.X     = x_q;
   assign bus.W     = w_q;
   assign bus.clr_n = clr_n_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
endmodule
